axis_rr_arbiter: RTL and testbench

Packet-aware round-robin arbiter that shares the write stream of one `fifo` instance among `NUM_REQ` AXI-stream requesters in the FIFO write-clock domain. It locks the grant for the duration of a packet or burst, so beats from different sources never interleave. It also stops issuing new grants while the FIFO reports `prog_full`, which keeps headroom for packets already in flight.

---
 rtl/axis_rr_arbiter.sv | 110 +++++++++++
 tb/tb_axis_rr_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin arbiter feeding one FIFO write port. A grant is held for a
// whole packet (or MAX_BURST beats), and new grants are withheld while prog_full is high.
module axis_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BUFF_WORD = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           s_valid_i,
    output logic [NUM_REQ-1:0]           s_ready_o,
    input  logic [NUM_REQ*BUFF_WORD-1:0] s_data_i,
    input  logic [NUM_REQ-1:0]           s_last_i,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic [BUFF_WORD-1:0]         m_data_o,
    output logic                         m_last_o,
    input  logic                         prog_full_i,
    output logic [NUM_REQ-1:0]           grant_o
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [PW-1:0]       rr_ptr_q;
    logic [PW-1:0]       rr_ptr_d;
    logic [CW-1:0]       beat_cnt_q;

    logic [PW-1:0]       gidx;
    logic                pick_vld;
    logic [PW-1:0]       pick_idx;
    logic [PW-1:0]       scan_idx;
    logic                accept;
    logic                release_beat;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant_q[i]) gidx = PW'(i);
    end

    // grant_q is all-zero in IDLE, so the output mux naturally drives zeros there
    always_comb begin
        m_valid_o = 1'b0;
        m_last_o  = 1'b0;
        m_data_o  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                m_valid_o = s_valid_i[i];
                m_last_o  = s_last_i[i];
                m_data_o  = s_data_i[i*BUFF_WORD +: BUFF_WORD];
            end
        end
    end

    assign s_ready_o = grant_q & {NUM_REQ{m_ready_i}};
    assign grant_o   = grant_q;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = PW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_vld && s_valid_i[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    assign accept       = s_valid_i[gidx] & m_ready_i;
    assign release_beat = accept & (s_last_i[gidx] |
                          ((MAX_BURST != 0) && (beat_cnt_q == CNT_LAST)));
    assign rr_ptr_d     = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!prog_full_i && pick_vld) begin
                        grant_q    <= NUM_REQ'(1) << pick_idx;
                        beat_cnt_q <= '0;
                        state_q    <= LOCK;
                    end
                end
                LOCK: begin
                    if (release_beat) begin
                        grant_q    <= '0;
                        rr_ptr_q   <= rr_ptr_d;
                        beat_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else if (accept) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: directed scenarios with literal beat logs, then random
// traffic, all checked each cycle against a grant-level behavioural model.
module tb_axis_rr_arbiter;
    localparam int N  = 4;
    localparam int BW = 32;
    localparam int MB = 4;
    localparam int PW = 2;

    logic            clk = 1'b0;
    logic            rst_i, m_ready_i, prog_full_i;
    logic            m_valid_o, m_last_o;
    logic [N-1:0]    s_valid_i, s_ready_o, s_last_i, grant_o;
    logic [N*BW-1:0] s_data_i;
    logic [BW-1:0]   m_data_o;

    always #5 clk = ~clk;

    axis_rr_arbiter #(.NUM_REQ(N), .BUFF_WORD(BW), .MAX_BURST(MB)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o),
        .prog_full_i(prog_full_i), .grant_o(grant_o)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    bit     chk_en  = 1'b0;
    bit     rand_mode = 1'b0;
    int     tc = 0;
    int     vprob = 100;
    int     rem[N];
    int     seq[N];
    int     exp_seq[N];
    bit     vprev[N];
    int     pq[N][$];
    logic [N-1:0] acc;
    int     log_q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s tc=%0d: got %0h expected %0h", name, tc, got, exp);
        end
    endtask

    // Model: which requester owns the write port, where the next search starts,
    // and how many beats the current owner has moved.
    int mg = -1;
    int mptr = 0;
    int mcnt = 0;

    always @(posedge clk) begin
        if (rst_i) begin
            mg <= -1; mptr <= 0; mcnt <= 0;
        end else if (mg < 0) begin
            if (!prog_full_i)
                for (int k = N - 1; k >= 0; k--)
                    if (s_valid_i[PW'((mptr + k) % N)]) mg <= (mptr + k) % N;
            mcnt <= 0;
        end else if (s_valid_i[PW'(mg)] && m_ready_i) begin
            if (s_last_i[PW'(mg)] || (mcnt + 1 == MB)) begin
                mg <= -1; mptr <= (mg + 1) % N; mcnt <= 0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0]  eg, er;
        logic          ev, el;
        logic [BW-1:0] ed;
        if (chk_en) begin
            eg = '0; er = '0; ev = 1'b0; el = 1'b0; ed = '0;
            if (mg >= 0) begin
                eg[PW'(mg)] = 1'b1;
                ev = s_valid_i[PW'(mg)];
                el = s_last_i[PW'(mg)];
                ed = s_data_i[mg*BW +: BW];
                er = m_ready_i ? eg : '0;
            end
            chk("grant",   64'(grant_o),   64'(eg));
            chk("m_valid", 64'(m_valid_o), 64'(ev));
            chk("m_last",  64'(m_last_o),  64'(el));
            chk("m_data",  64'(m_data_o),  64'(ed));
            chk("s_ready", 64'(s_ready_o), 64'(er));
        end
    end

    task automatic load(input int i, input int len);
        if (rem[i] == 0) rem[i] = len;
        else pq[i].push_back(len);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_valid_i[i] = (rem[i] > 0) && (vprev[i] || (($urandom % 100) < vprob));
            s_last_i[i]  = (rem[i] == 1);
            s_data_i[i*BW +: BW] = {8'(i), 24'(seq[i])};
        end
    endtask

    task automatic advance();
        for (int i = 0; i < N; i++) begin
            if (rst_i) begin
                rem[i] = 0; vprev[i] = 1'b0; pq[i].delete();
                exp_seq[i] = seq[i];
            end else begin
                if (acc[i]) begin seq[i]++; rem[i]--; end
                vprev[i] = s_valid_i[i] && !acc[i];
                if (rem[i] == 0 && pq[i].size() > 0) rem[i] = pq[i].pop_front();
                if (rand_mode && rem[i] == 0 && ($urandom % 100) < 30)
                    rem[i] = $urandom_range(1, 10);
            end
        end
    endtask

    // One clock: drive inputs, observe the handshake mid-cycle, step sources after the edge.
    task automatic cyc1();
        drive();
        @(negedge clk);
        acc = rst_i ? '0 : (s_valid_i & s_ready_o);
        if (!rst_i && m_valid_o && m_ready_i) begin
            int id;
            id = int'(m_data_o[31:24]);
            log_q.push_back(tc * 100 + id * 10 + int'(m_last_o));
            if (id < N) begin
                chk("seq", 64'(m_data_o[23:0]), 64'(exp_seq[id]));
                exp_seq[id]++;
            end else begin
                chk("src_id", 64'(id), 64'(0));
            end
        end
        @(posedge clk);
        #1;
        advance();
        tc++;
    endtask

    task automatic do_reset(input bit check_state);
        rst_i = 1'b1; prog_full_i = 1'b0; m_ready_i = 1'b1; vprob = 100;
        for (int i = 0; i < N; i++) begin rem[i] = 0; vprev[i] = 1'b0; pq[i].delete(); end
        cyc1();
        if (check_state) begin
            #2;
            chk("rst_grant",   64'(grant_o),   64'(0));
            chk("rst_m_valid", 64'(m_valid_o), 64'(0));
            chk("rst_m_last",  64'(m_last_o),  64'(0));
            chk("rst_m_data",  64'(m_data_o),  64'(0));
            chk("rst_s_ready", 64'(s_ready_o), 64'(0));
        end
        cyc1();
        rst_i = 1'b0; tc = 0; log_q.delete();
    endtask

    task automatic check_log(input string name, input int exp[$]);
        chk({name, "_len"}, 64'(log_q.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < log_q.size(); i++)
            chk(name, 64'(log_q[i]), 64'(exp[i]));
    endtask

    initial begin
        int exp[$];
        rst_i = 1'b1; m_ready_i = 1'b1; prog_full_i = 1'b0;
        s_valid_i = '0; s_last_i = '0; s_data_i = '0; acc = '0;
        for (int i = 0; i < N; i++) begin seq[i] = 0; exp_seq[i] = 0; end

        do_reset(1'b1);
        chk_en = 1'b1;

        // Two 3-beat packets, then 0 and 3 together show the pointer moved to 3
        load(0, 3); load(2, 3);
        for (int c = 0; c < 13; c++) begin
            if (c == 8) begin load(0, 1); load(3, 1); end
            cyc1();
        end
        exp = {100, 200, 301, 520, 620, 721, 931, 1101};
        check_log("two_pkts", exp);

        // Continuous single-beat packets from everyone
        do_reset(1'b0);
        for (int i = 0; i < N; i++) repeat (4) load(i, 1);
        repeat (17) cyc1();
        exp = {101, 311, 521, 731, 901, 1111, 1321, 1531};
        check_log("rr_order", exp);

        // Burst limit splits a 10-beat packet around requester 3
        do_reset(1'b0);
        load(1, 10); load(3, 4);
        repeat (19) cyc1();
        exp = {110, 210, 310, 410, 630, 730, 830, 931, 1110, 1210, 1310, 1410, 1610, 1711};
        check_log("burst", exp);

        // prog_full blocks new grants but not a packet already granted
        do_reset(1'b0);
        load(0, 3);
        for (int c = 0; c < 12; c++) begin
            prog_full_i = (c <= 5) || (c >= 8);
            if (c <= 6) chk("pf_hold", 64'(grant_o), 64'(0));
            if (c == 7) chk("pf_grant", 64'(grant_o), 64'(1));
            cyc1();
        end
        exp = {700, 800, 901};
        check_log("prog_full", exp);

        // Back-pressure toggling mid-packet
        do_reset(1'b0);
        load(2, 4);
        for (int c = 0; c < 9; c++) begin
            m_ready_i = (c == 0) || (c % 2 == 1);
            cyc1();
        end
        exp = {120, 320, 520, 721};
        check_log("m_ready", exp);

        // Reset on beat 2 abandons the packet and restarts arbitration at 0
        do_reset(1'b0);
        load(1, 5);
        for (int c = 0; c < 8; c++) begin
            rst_i = (c == 2);
            if (c == 3) begin
                chk("mid_rst_grant",   64'(grant_o),   64'(0));
                chk("mid_rst_m_valid", 64'(m_valid_o), 64'(0));
                load(0, 1); load(2, 1);
            end
            cyc1();
        end
        exp = {110, 401, 621};
        check_log("mid_rst", exp);

        // Random traffic against the model
        do_reset(1'b0);
        rand_mode = 1'b1;
        begin
            int pf_pct;
            pf_pct = 0;
            for (int c = 0; c < 3000; c++) begin
                if (c % 300 == 0) vprob = $urandom_range(30, 100);
                if (c % 100 == 0) pf_pct = ($urandom % 3 == 0) ? int'($urandom_range(20, 90)) : 0;
                m_ready_i   = ($urandom % 100) < 75;
                prog_full_i = ($urandom % 100) < pf_pct;
                rst_i       = ($urandom % 700) == 0;
                cyc1();
            end
        end
        rst_i = 1'b0;
        rand_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
